multicycle_alu: RTL

//  Execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder.

---
 rtl/multicycle_alu.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
// EX-stage ALU: single-cycle logic/arith/compare, iterative mult/div.
// start/busy/done handshake lets the controller stall during long ops.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALU_Control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] OP_DIV = 4'h0;
  localparam logic [3:0] OP_MUL = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_LT  = 4'h6;
  localparam logic [3:0] OP_LE  = 4'h7;
  localparam logic [3:0] OP_GT  = 4'h8;
  localparam logic [3:0] OP_GE  = 4'h9;
  localparam logic [3:0] OP_EQ  = 4'ha;
  localparam logic [3:0] OP_NE  = 4'hb;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_d;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic             div0;

  logic [WIDTH-1:0] sc_res;
  logic             sc_err;
  logic             cmp;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_n;
  logic [WIDTH-1:0] mul_mq_n;

  logic [WIDTH:0]   div_sh;
  logic [WIDTH+1:0] div_tr;
  logic             div_ok;
  logic [WIDTH-1:0] div_acc_n;
  logic [WIDTH-1:0] div_mq_n;

  logic last;

  assign busy = (state == S_MUL) || (state == S_DIV);
  assign done = (state == S_DONE);
  assign last = (cnt == CW'(1));

  always_comb begin
    sc_res = '0;
    sc_err = 1'b0;
    cmp    = 1'b0;
    unique case (1'b1)
      (ALU_Control == OP_DIV),
      (ALU_Control == OP_MUL): sc_res = '0;
      (ALU_Control == OP_SUB): sc_res = a - b;
      (ALU_Control == OP_ADD): sc_res = a + b;
      (ALU_Control == OP_OR):  sc_res = a | b;
      (ALU_Control == OP_AND): sc_res = a & b;
      (ALU_Control == OP_LT):  cmp = $signed(a) <  $signed(b);
      (ALU_Control == OP_LE):  cmp = $signed(a) <= $signed(b);
      (ALU_Control == OP_GT):  cmp = $signed(a) >  $signed(b);
      (ALU_Control == OP_GE):  cmp = $signed(a) >= $signed(b);
      (ALU_Control == OP_EQ):  cmp = (a == b);
      (ALU_Control == OP_NE):  cmp = (a != b);
      default:                 sc_err = 1'b1;
    endcase
    if (cmp) sc_res = {{(WIDTH-1){1'b0}}, 1'b1};
  end

  // Shift-add: acc holds the running high word, mq the multiplier
  // being shifted out while product low bits shift in from the top.
  always_comb begin
    mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, op_d} : '0);
    mul_acc_n = mul_sum[WIDTH:1];
    mul_mq_n  = {mul_sum[0], mq[WIDTH-1:1]};
  end

  // Restoring divide; the extra guard bit keeps the borrow honest
  // when a zero divisor lets the partial remainder fill all WIDTH bits.
  always_comb begin
    div_sh    = {acc, mq[WIDTH-1]};
    div_tr    = {1'b0, div_sh} - {2'b00, op_d};
    div_ok    = ~div_tr[WIDTH+1];
    div_acc_n = div_ok ? div_tr[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_mq_n  = {mq[WIDTH-2:0], div_ok};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_d   <= '0;
      acc    <= '0;
      mq     <= '0;
      div0   <= 1'b0;
      result <= '0;
      hi     <= '0;
      zero   <= 1'b0;
      err    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (ALU_Control == OP_MUL) begin
              op_d  <= a;
              mq    <= b;
              acc   <= '0;
              cnt   <= CW'(WIDTH);
              state <= S_MUL;
            end else if (ALU_Control == OP_DIV) begin
              op_d  <= b;
              mq    <= a;
              acc   <= '0;
              div0  <= (b == '0);
              cnt   <= CW'(WIDTH);
              state <= S_DIV;
            end else begin
              result <= sc_res;
              hi     <= '0;
              zero   <= (sc_res == '0);
              err    <= sc_err;
              state  <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc <= mul_acc_n;
          mq  <= mul_mq_n;
          cnt <= cnt - CW'(1);
          if (last) begin
            result <= mul_mq_n;
            hi     <= mul_acc_n;
            zero   <= (mul_mq_n == '0);
            err    <= 1'b0;
            state  <= S_DONE;
          end
        end
        S_DIV: begin
          acc <= div_acc_n;
          mq  <= div_mq_n;
          cnt <= cnt - CW'(1);
          if (last) begin
            result <= div_mq_n;
            hi     <= div_acc_n;
            zero   <= (div_mq_n == '0);
            err    <= div0;
            state  <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
      endcase
    end
  end

endmodule
